// File: rtl/packet_store_crc.sv
// packet_store_crc: stores received packets in a ring buffer. A packet is committed only when its CRC is good and
// a descriptor slot is free. Committed packets are read back one word at a time, whole packet by whole packet.
module packet_store_crc #(
  parameter int pDATA_W = 8,
  parameter int pADDR_W = 14,
  parameter int pLEN_W  = 16,
  parameter int pDESC_W = 4
) (
  input  logic               iclk,
  input  logic               i_rst,
  input  logic               idv,
  input  logic [pDATA_W-1:0] irx_d,
  input  logic               ieop,
  input  logic               icrc_ok,
  input  logic               ird_req,
  input  logic               ird_en,
  output logic [pDATA_W-1:0] or_data,
  output logic               ordv,
  output logic               olast,
  output logic [pLEN_W-1:0]  olen_pac,
  output logic               oempty,
  output logic               ofull,
  output logic [15:0]        odrop_cnt
);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, CHECK = 2'd2, DROP = 2'd3;
  localparam logic RD_IDLE = 1'b0, RD_PKT = 1'b1;
  logic [pDATA_W-1:0] r_mem [2**pADDR_W];
  logic [pLEN_W-1:0]  r_desc [2**pDESC_W];
  logic [1:0]         r_st;
  logic               r_rs;
  logic [pADDR_W-1:0] r_wr_tmp, r_wr_commit, r_rd_ptr;
  logic [pLEN_W-1:0]  r_len, r_rem, r_len_pac;
  logic               r_crc;
  logic [pDESC_W-1:0] r_dwp, r_drp;
  logic [pDESC_W:0]   r_dcnt;
  logic [pDATA_W-1:0] r_data;
  logic               r_dv, r_last;
  logic [15:0]        r_drop;
  logic               w_wr_side, w_ring_full, w_ovf, w_we, w_push, w_pop, w_bad, w_end;
  logic [16:0]        w_drop_sum;
  assign oempty      = r_dcnt == '0;
  assign ofull       = r_dcnt[pDESC_W];
  assign w_wr_side   = r_st == IDLE || r_st == WRITE;
  assign w_ring_full = r_wr_tmp + pADDR_W'(1) == r_rd_ptr;
  assign w_ovf       = w_ring_full || (r_st == IDLE ? ofull : &r_len);
  assign w_we        = idv && w_wr_side && !w_ovf;
  assign w_push      = r_st == CHECK && r_crc && !ofull;
  assign w_bad       = r_st == CHECK && !w_push;
  assign w_pop       = r_rs == RD_IDLE && ird_req && !oempty;
  // a discarded packet (including one that starts during CHECK) is counted when its last word arrives
  assign w_end       = idv && ieop && (r_st == DROP || r_st == CHECK || (w_wr_side && w_ovf));
  assign w_drop_sum  = 17'(r_drop) + 17'(w_bad) + 17'(w_end);
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      r_st        <= IDLE;
      r_wr_tmp    <= '0;
      r_wr_commit <= '0;
      r_len       <= '0;
      r_crc       <= 1'b0;
      r_drop      <= '0;
    end else begin
      r_drop <= w_drop_sum[16] ? '1 : w_drop_sum[15:0];
      case (r_st)
        IDLE, WRITE: if (idv) begin
          if (w_ovf) begin
            r_st <= ieop ? IDLE : DROP;
            if (ieop) r_wr_tmp <= r_wr_commit;
          end else begin
            r_wr_tmp <= r_wr_tmp + pADDR_W'(1);
            r_len    <= r_st == IDLE ? pLEN_W'(1) : r_len + pLEN_W'(1);
            r_crc    <= icrc_ok;
            r_st     <= ieop ? CHECK : WRITE;
          end
        end
        CHECK: begin
          if (w_push) r_wr_commit <= r_wr_tmp;
          else r_wr_tmp <= r_wr_commit;
          r_st <= idv && !ieop ? DROP : IDLE;
        end
        default: if (idv && ieop) begin
          r_wr_tmp <= r_wr_commit;
          r_st     <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge iclk) begin
    if (w_we) r_mem[r_wr_tmp] <= irx_d;
    if (w_push) r_desc[r_dwp] <= r_len;
  end
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      r_dwp     <= '0;
      r_drp     <= '0;
      r_dcnt    <= '0;
      r_rs      <= RD_IDLE;
      r_rd_ptr  <= '0;
      r_rem     <= '0;
      r_len_pac <= '0;
      r_data    <= '0;
      r_dv      <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_dwp  <= r_dwp + pDESC_W'(w_push);
      r_drp  <= r_drp + pDESC_W'(w_pop);
      r_dcnt <= r_dcnt + (pDESC_W+1)'(w_push) - (pDESC_W+1)'(w_pop);
      r_dv   <= 1'b0;
      r_last <= 1'b0;
      if (w_pop) begin
        r_len_pac <= r_desc[r_drp];
        r_rem     <= r_desc[r_drp];
        r_rs      <= RD_PKT;
      end else if (r_rs == RD_PKT && ird_en) begin
        r_data   <= r_mem[r_rd_ptr];
        r_dv     <= 1'b1;
        r_last   <= r_rem == pLEN_W'(1);
        r_rd_ptr <= r_rd_ptr + pADDR_W'(1);
        r_rem    <= r_rem - pLEN_W'(1);
        if (r_rem == pLEN_W'(1)) r_rs <= RD_IDLE;
      end
    end
  end
  assign or_data   = r_data;
  assign ordv      = r_dv;
  assign olast     = r_last;
  assign olen_pac  = r_len_pac;
  assign odrop_cnt = r_drop;
endmodule

// File: tb/tb_packet_store_crc.sv
// tb_packet_store_crc: a default-sized store and a 16-word-ring store, each checked every cycle against a queue model
module tb_packet_store_crc;
  localparam int DD = 16;
  localparam int M_IDLE = 0, M_IN = 1, M_VERDICT = 2, M_DISCARD = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst[2], dv[2], eop[2], crc[2], req[2], en[2];
  logic [7:0] d[2];
  logic [7:0] q_data[2];
  logic q_dv[2], q_last[2], q_empty[2], q_full[2];
  logic [15:0] q_len[2], q_drop[2];
  int n_chk = 0, n_err = 0;
  packet_store_crc u_big (
    .iclk(clk), .i_rst(rst[0]), .idv(dv[0]), .irx_d(d[0]), .ieop(eop[0]), .icrc_ok(crc[0]),
    .ird_req(req[0]), .ird_en(en[0]), .or_data(q_data[0]), .ordv(q_dv[0]), .olast(q_last[0]),
    .olen_pac(q_len[0]), .oempty(q_empty[0]), .ofull(q_full[0]), .odrop_cnt(q_drop[0]));
  packet_store_crc #(.pADDR_W(4)) u_small (
    .iclk(clk), .i_rst(rst[1]), .idv(dv[1]), .irx_d(d[1]), .ieop(eop[1]), .icrc_ok(crc[1]),
    .ird_req(req[1]), .ird_en(en[1]), .or_data(q_data[1]), .ordv(q_dv[1]), .olast(q_last[1]),
    .olen_pac(q_len[1]), .oempty(q_empty[1]), .ofull(q_full[1]), .odrop_cnt(q_drop[1]));
  // ring keeps one slot free, so it holds one word less than its depth
  int cap[2] = '{16383, 15};
  logic [7:0] m_ring[2][$];
  logic [7:0] m_part[2][$];
  int m_desc[2][$];
  int m_mode[2], m_rem[2], e_len[2], e_drop[2];
  bit m_crc[2], m_rd[2], e_dv[2], e_last[2];
  logic [7:0] e_data[2];
  bit armed = 0;
  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, n, act, exp, $time);
    end
  endtask
  task automatic model_step(input int n);
    bit full, empty;
    int occ, dinc;
    if (rst[n]) begin
      m_ring[n].delete(); m_part[n].delete(); m_desc[n].delete();
      m_mode[n] = M_IDLE; m_rd[n] = 0; m_rem[n] = 0; m_crc[n] = 0;
      e_data[n] = 0; e_dv[n] = 0; e_last[n] = 0; e_len[n] = 0; e_drop[n] = 0;
      return;
    end
    full  = m_desc[n].size() == DD;
    empty = m_desc[n].size() == 0;
    occ   = m_ring[n].size() + m_part[n].size();
    dinc  = 0;
    e_dv[n] = 0;
    e_last[n] = 0;
    if (!m_rd[n]) begin
      if (req[n] && !empty) begin
        e_len[n] = m_desc[n].pop_front();
        m_rem[n] = e_len[n];
        m_rd[n] = 1;
      end
    end else if (en[n]) begin
      e_data[n] = m_ring[n].pop_front();
      e_dv[n] = 1;
      e_last[n] = m_rem[n] == 1;
      m_rem[n]--;
      if (m_rem[n] == 0) m_rd[n] = 0;
    end
    case (m_mode[n])
      M_IDLE, M_IN: if (dv[n]) begin
        if (occ == cap[n] || (m_mode[n] == M_IDLE ? full : m_part[n].size() == 65535)) begin
          m_part[n].delete();
          if (eop[n]) begin dinc++; m_mode[n] = M_IDLE; end
          else m_mode[n] = M_DISCARD;
        end else begin
          m_part[n].push_back(d[n]);
          m_crc[n] = crc[n];
          m_mode[n] = eop[n] ? M_VERDICT : M_IN;
        end
      end
      M_VERDICT: begin
        if (m_crc[n] && !full) begin
          m_desc[n].push_back(m_part[n].size());
          for (int k = 0; k < m_part[n].size(); k++) m_ring[n].push_back(m_part[n][k]);
        end else dinc++;
        m_part[n].delete();
        m_mode[n] = M_IDLE;
        if (dv[n]) begin
          if (eop[n]) dinc++;
          else m_mode[n] = M_DISCARD;
        end
      end
      default: if (dv[n] && eop[n]) begin dinc++; m_mode[n] = M_IDLE; end
    endcase
    e_drop[n] = e_drop[n] + dinc > 65535 ? 65535 : e_drop[n] + dinc;
  endtask
  task automatic cmp(input int n);
    chk("or_data", n, q_data[n], e_data[n]);
    chk("ordv", n, q_dv[n], e_dv[n]);
    chk("olast", n, q_last[n], e_last[n]);
    chk("olen_pac", n, q_len[n], e_len[n]);
    chk("oempty", n, q_empty[n], m_desc[n].size() == 0);
    chk("ofull", n, q_full[n], m_desc[n].size() == DD);
    chk("odrop_cnt", n, q_drop[n], e_drop[n]);
  endtask
  initial forever begin
    @(negedge clk);
    if (armed) for (int n = 0; n < 2; n++) cmp(n);
    for (int n = 0; n < 2; n++) model_step(n);
    if (rst[0] && rst[1]) armed = 1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int c);
    repeat (c) tick();
  endtask
  task automatic send(input int n, input int len, input logic [7:0] base, input logic ok);
    for (int k = 0; k < len; k++) begin
      dv[n] = 1; d[n] = base + 8'(k); eop[n] = k == len - 1; crc[n] = ok;
      tick();
    end
    dv[n] = 0; eop[n] = 0;
  endtask
  task automatic pop(input int n, input int len);
    req[n] = 1;
    tick();
    req[n] = 0;
    chk("pop_len", n, q_len[n], len);
  endtask
  task automatic drain(input int n, input int len, input logic [7:0] base);
    logic [7:0] w;
    for (int k = 0; k < len; k++) begin
      en[n] = 1;
      tick();
      w = base + 8'(k);
      chk("word", n, q_data[n], w);
      chk("word_dv", n, q_dv[n], 1);
      chk("word_last", n, q_last[n], k == len - 1);
    end
    en[n] = 0;
  endtask
  task automatic reset_vals(input int n);
    chk("rst_data", n, q_data[n], 0);
    chk("rst_dv", n, q_dv[n], 0);
    chk("rst_last", n, q_last[n], 0);
    chk("rst_len", n, q_len[n], 0);
    chk("rst_empty", n, q_empty[n], 1);
    chk("rst_full", n, q_full[n], 0);
    chk("rst_drop", n, q_drop[n], 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    for (int n = 0; n < 2; n++) begin
      rst[n] = 1; dv[n] = 0; eop[n] = 0; crc[n] = 0; req[n] = 0; en[n] = 0; d[n] = 0;
    end
    idle(3);
    rst[0] = 0; rst[1] = 0;
    reset_vals(0);
    reset_vals(1);
    send(0, 64, 8'h00, 1); idle(2);
    chk("stored_not_empty", 0, q_empty[0], 0);
    pop(0, 64); drain(0, 64, 8'h00);
    chk("drained_empty", 0, q_empty[0], 1);
    en[0] = 1; tick(); en[0] = 0;
    chk("idle_en_ignored", 0, q_dv[0], 0);
    send(0, 10, 8'h80, 0); idle(2);
    chk("bad_crc_empty", 0, q_empty[0], 1);
    chk("bad_crc_drop", 0, q_drop[0], 1);
    send(0, 5, 8'h40, 1); idle(2);
    pop(0, 5); drain(0, 5, 8'h40);
    send(0, 2, 8'h11, 1); idle(2);
    send(0, 2, 8'h22, 1);
    pop(0, 2);
    chk("push_pop_count", 0, q_empty[0], 0);
    drain(0, 2, 8'h11);
    pop(0, 2); drain(0, 2, 8'h22);
    send(0, 3, 8'h30, 1); idle(2);
    send(0, 4, 8'h38, 1); idle(2);
    pop(0, 3);
    req[0] = 1; tick(); req[0] = 0;
    chk("req_in_pkt_len", 0, q_len[0], 3);
    drain(0, 3, 8'h30);
    pop(0, 4); drain(0, 4, 8'h38);
    for (int p = 0; p < DD; p++) begin
      send(0, 3, 8'(p * 4), 1); idle(2);
    end
    chk("fifo_full", 0, q_full[0], 1);
    send(0, 3, 8'hF0, 1); idle(2);
    chk("full_drop", 0, q_drop[0], 2);
    chk("still_full", 0, q_full[0], 1);
    for (int p = 0; p < DD; p++) begin
      pop(0, 3); drain(0, 3, 8'(p * 4));
    end
    chk("fifo_emptied", 0, q_empty[0], 1);
    chk("fifo_not_full", 0, q_full[0], 0);
    send(1, 20, 8'h00, 1); idle(2);
    chk("ring_ovf_drop", 1, q_drop[1], 1);
    chk("ring_ovf_empty", 1, q_empty[1], 1);
    send(1, 10, 8'h50, 1); idle(2);
    pop(1, 10); drain(1, 10, 8'h50);
    send(1, 10, 8'h60, 1); idle(2);
    pop(1, 10); drain(1, 10, 8'h60);
    send(1, 15, 8'h70, 1); idle(2);
    chk("ring_exact_fit", 1, q_drop[1], 1);
    pop(1, 15); drain(1, 15, 8'h70);
    send(1, 16, 8'h90, 1); idle(2);
    chk("ring_one_over", 1, q_drop[1], 2);
    send(0, 8, 8'hA0, 1); idle(2);
    pop(0, 8);
    for (int k = 0; k < 3; k++) begin
      en[0] = 1; dv[0] = 1; d[0] = 8'hC0 + 8'(k);
      tick();
    end
    en[0] = 0; dv[0] = 0; rst[0] = 1;
    tick();
    rst[0] = 0;
    reset_vals(0);
    send(0, 4, 8'hD0, 1); idle(2);
    pop(0, 4); drain(0, 4, 8'hD0);
    chk("post_reset_drop", 0, q_drop[0], 0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/packet_store_crc.md
PACKET_STORE_CRC -- requirements
Module: packet_store_crc

Interface
REQ-001 SHALL have parameter pDATA_W, default 8, meaning byte-lane width of stored data.
REQ-002 SHALL have parameter pADDR_W, default 14, meaning ring-buffer address width; depth is 2^pADDR_W words.
REQ-003 SHALL have parameter pLEN_W, default 16, meaning packet-length field width.
REQ-004 SHALL have parameter pDESC_W, default 4, meaning descriptor-FIFO address width; depth is 2^pDESC_W entries.
REQ-005 SHALL have port iclk, input, 1, meaning the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-007 SHALL have port idv, input, 1, meaning receive-word valid.
REQ-008 SHALL have port irx_d, input, pDATA_W, meaning receive word.
REQ-009 SHALL have port ieop, input, 1, meaning last word of packet; qualified by idv.
REQ-010 SHALL have port icrc_ok, input, 1, meaning CRC verdict; sampled with idv&ieop.
REQ-011 SHALL have port ird_req, input, 1, meaning pop the next stored packet.
REQ-012 SHALL have port ird_en, input, 1, meaning read the next word of the current packet.
REQ-013 SHALL have port or_data, output, pDATA_W, meaning read word.
REQ-014 SHALL have port ordv, output, 1, meaning or_data valid.
REQ-015 SHALL have port olast, output, 1, meaning or_data is the final word of the packet.
REQ-016 SHALL have port olen_pac, output, pLEN_W, meaning length of the packet being read.
REQ-017 SHALL have port oempty, output, 1, and port ofull, output, 1, meaning descriptor-FIFO empty/full.
REQ-018 SHALL have port odrop_cnt, output, 16, meaning saturating count of discarded packets.

Function
REQ-019 Write FSM SHALL have states IDLE, WRITE, CHECK, DROP.
REQ-020 IDLE: idv SHALL write irx_d at wr_tmp, set len=1, wr_tmp+1, go WRITE (or CHECK if ieop same cycle).
REQ-021 WRITE: each idv SHALL write a word, increment wr_tmp and len; idv&ieop SHALL latch icrc_ok and go CHECK.
REQ-022 Overflow (wr_tmp+1 == rd_ptr, len == 2^pLEN_W-1, or ofull at packet start) SHALL suppress writes and go DROP.
REQ-023 DROP: words SHALL be ignored until idv&ieop, then wr_tmp SHALL restore to wr_commit, odrop_cnt increments, go IDLE.
REQ-024 CHECK (one cycle): crc_ok & !ofull SHALL push len to the descriptor FIFO and set wr_commit=wr_tmp; otherwise wr_tmp SHALL restore to wr_commit and odrop_cnt increments; next state IDLE.
REQ-025 idv during CHECK SHALL start a packet that is dropped (go DROP after CHECK action).
REQ-026 All ring pointers SHALL wrap modulo 2^pADDR_W; lengths SHALL not wrap (REQ-022 caps them).
REQ-027 Read FSM SHALL have states RD_IDLE, RD_PKT; RD_IDLE with ird_req & !oempty SHALL pop one descriptor, load olen_pac and remaining, go RD_PKT.
REQ-028 RD_PKT: ird_en SHALL read at rd_ptr, increment rd_ptr, decrement remaining; or_data/ordv SHALL appear 1 cycle later.
REQ-029 olast SHALL assert with ordv of the word read when remaining was 1; the FSM SHALL then return to RD_IDLE.
REQ-030 ird_req in RD_PKT and ird_en in RD_IDLE SHALL be ignored.
REQ-031 Simultaneous push (CHECK) and pop (RD_IDLE) SHALL both complete; oempty/ofull reflect the net count next cycle.
REQ-032 Uncommitted words SHALL never be readable; free space SHALL be computed against rd_ptr.

Reset
REQ-033 i_rst SHALL clear all pointers, len, remaining, descriptor count, odrop_cnt; FSMs to IDLE/RD_IDLE.
REQ-034 Reset outputs: or_data=0, ordv=0, olast=0, olen_pac=0, oempty=1, ofull=0, odrop_cnt=0.
REQ-035 Reset mid-packet SHALL discard the partial packet without incrementing odrop_cnt.

Verification
REQ-036 Write 64-word packet, icrc_ok=1 -> oempty=0; ird_req then 64 ird_en -> words 0..63 in order, olen_pac=64, olast on word 64.
REQ-037 Write 10-word packet with icrc_ok=0 -> oempty stays 1, odrop_cnt=1, next good packet stored at the same start address.
REQ-038 With pADDR_W=4, write 20-word packet -> DROP, odrop_cnt=1, ring unchanged.
REQ-039 Fill 2^pDESC_W good packets -> ofull=1; next good packet dropped, odrop_cnt=1.
REQ-040 Read packet across ring wrap (pADDR_W=4, two 10-word packets) -> data intact after pointer wraps to 0.
REQ-041 Assert i_rst mid-write and mid-read -> all outputs at REQ-034 values next cycle.
